div_sequencer: RTL
==================

// Module: div_sequencer
// PURPOSE
//   Multi-cycle sequencer for the DIV/DIVU datapath: accepts one divide request from EX,
//   runs a 32-step restoring divide, stalls the pipeline meanwhile, and returns {HI=rem, LO=quot}.
//   Sits beside the single-cycle ALU in EX; result feeds the HI/LO register write path.
// PARAMETERS
//   WIDTH       32   operand width (quotient/remainder each WIDTH bits)
//   CNT_W       5    step-counter width, equals clog2(WIDTH)
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        synchronous, active-high reset
//   start        in   1        divide request from EX (decoded DIV/DIVU)
//   signed_div   in   1        1 = DIV (two's complement), 0 = DIVU
//   opdata_a     in   WIDTH    dividend (rs)
//   opdata_b     in   WIDTH    divisor (rt)
//   annul        in   1        flush from exception/branch logic; abandons current op
//   result       out  2*WIDTH  {remainder, quotient}; valid when ready=1, held until next accept
//   ready        out  1        one-cycle pulse: result valid
//   stall        out  1        hold IF/ID/EX while the divide is in flight
// BEHAVIOUR
//   Reset: state=IDLE, counter=0, result=0, ready=0, stall=0 (stall also 0 during the rst cycle).
//   States: IDLE -> CALC -> DONE -> IDLE.
//   - IDLE: start=1 & annul=0 -> latch |a|,|b| (abs only if signed_div), quotient sign
//     (a[MSB]^b[MSB])&signed_div, remainder sign a[MSB]&signed_div; counter<=0; go CALC.
//     stall = start & ~annul (combinational) in IDLE.
//   - CALC: one restoring step per cycle (shift-subtract, quotient bit = no-borrow);
//     counter++; after step WIDTH-1 (counter==WIDTH-1) go DONE. stall=1 throughout.
//   - DONE: result <= sign-corrected {rem, quot}; ready=1 for exactly this cycle; stall=0;
//     go IDLE unconditionally. start in DONE is ignored (EX holds a new instr next cycle).
//   Latency: start accepted cycle 0 -> ready at cycle WIDTH+1 (33 for WIDTH=32).
//   Sign fix: quot negated if quot-sign set; rem negated if rem-sign set (rem sign = dividend).
//   0x80000000 / -1 (signed): quot wraps to 0x80000000, rem = 0; no trap.
//   Divide by zero: result = {opdata_a, {WIDTH{1'b1}}} for both DIV and DIVU (override sign fix).
//   annul: in any state, next state IDLE, ready stays 0, result retains previous value;
//     annul same cycle as start in IDLE -> request not accepted. annul has priority over start.
//   rst mid-operation: identical to reset values next cycle; no ready pulse.
//   Operands are sampled only on accept; later changes on opdata_a/b have no effect.
// CONFIGURATION
//   DIV_ZERO_FAST_EN defined: opdata_b==0 on accept goes IDLE -> DONE directly
//     (ready at cycle 1, stall only in accept cycle); result as above.
//   Not defined: divide-by-zero runs full WIDTH CALC steps; same result, latency WIDTH+1.
// STRUCTURE
//   Shared defines header (defines2.vh): DIV_IDLE/DIV_CALC/DIV_DONE state encodings (2 bits),
//     DIV_CYCLES = 32, DIV/DIVU funct codes already present there.
//   Sub-module div_step: combinational single restoring iteration
//     (in: partial rem, dividend bit, divisor; out: next rem, quotient bit).
//   Sequencer owns FSM, counter, operand/sign registers, output register.
// TESTING
//   DIVU 100/7 -> ready at cycle 33, result={32'd2, 32'd14}, stall high cycles 0..32.
//   DIV -7/2 (0xFFFFFFF9, 2) -> quot 0xFFFFFFFD, rem 0xFFFFFFFF.
//   DIV 0x80000000 / 0xFFFFFFFF -> quot 0x80000000, rem 0; DIVU same operands -> quot 0, rem 0x80000000.
//   DIVU 5/0 -> {32'd5, 32'hFFFFFFFF}; ready at 33 without macro, at cycle 1 with DIV_ZERO_FAST_EN.
//   annul at CALC step 10 -> IDLE next cycle, no ready, stall drops, result unchanged; new start accepted.
//   rst asserted mid-CALC -> all outputs 0 next cycle; start in DONE cycle ignored (no second ready).

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// ============================================================================
// Module  : div_sequencer_pkg
// Purpose : Shared state encoding and sizing constants for the divide sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_sequencer_pkg;

  localparam int DIV_CYCLES  = 32;
  localparam int DIV_STATE_W = 2;

  typedef enum logic [DIV_STATE_W-1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

endpackage : div_sequencer_pkg

`default_nettype wire

// File: rtl/div_sequencer_step.sv
// ============================================================================
// Module  : div_sequencer_step
// Purpose : One combinational restoring-divide iteration (shift in a dividend
//           bit, subtract divisor when no borrow, emit the quotient bit).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sequencer_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;

  assign w_shift = {i_rem, i_bit};
  // Low bits of the difference are exact whenever the subtraction does not borrow.
  assign w_sub   = w_shift[WIDTH-1:0] - i_divisor;
  assign o_q     = (w_shift >= {1'b0, i_divisor});
  assign o_rem   = o_q ? w_sub : w_shift[WIDTH-1:0];

endmodule : div_sequencer_step

`default_nettype wire

// File: rtl/div_sequencer.sv
// ============================================================================
// Module  : div_sequencer
// Purpose : Multi-cycle DIV/DIVU sequencer, WIDTH-step restoring divide with
//           pipeline stall and {remainder, quotient} result register.
//           Optional macro DIV_ZERO_FAST_EN: divide-by-zero skips the CALC steps.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_CYCLES,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata_a,
  input  logic [WIDTH-1:0]   opdata_b,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  div_state_t         r_state;
  div_state_t         w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_a_raw;
  logic               r_qsign;
  logic               r_rsign;
  logic               r_div_zero;
  logic [2*WIDTH-1:0] r_result;

  logic               w_accept;
  logic               w_last;
  logic               w_b_zero;
  logic               w_step_q;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH-1:0]   w_step_rem;
  logic [WIDTH-1:0]   w_quot_next;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2*WIDTH-1:0] w_final;

  assign w_accept = (r_state == DIV_IDLE) && start && !annul;
  assign w_b_zero = (opdata_b == '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_a_abs  = (signed_div && opdata_a[WIDTH-1]) ? -opdata_a : opdata_a;
  assign w_b_abs  = (signed_div && opdata_b[WIDTH-1]) ? -opdata_b : opdata_b;

  div_sequencer_step #(
    .WIDTH     (WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_quot[WIDTH-1]),
    .i_divisor (r_divisor),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  // The dividend register shifts out its MSB each step and collects quotient bits at the LSB.
  assign w_quot_next = {r_quot[WIDTH-2:0], w_step_q};
  assign w_quot_fix  = r_qsign ? -w_quot_next : w_quot_next;
  assign w_rem_fix   = r_rsign ? -w_step_rem  : w_step_rem;
  assign w_final     = r_div_zero ? {r_a_raw, {WIDTH{1'b1}}} : {w_rem_fix, w_quot_fix};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    ready        = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        if (start && !annul) begin
          stall = 1'b1;
`ifdef DIV_ZERO_FAST_EN
          w_next_state = w_b_zero ? DIV_DONE : DIV_CALC;
`else
          w_next_state = DIV_CALC;
`endif
        end
      end
      DIV_CALC: begin
        stall = 1'b1;
        if (w_last) begin
          w_next_state = DIV_DONE;
        end
      end
      DIV_DONE: begin
        ready        = 1'b1;
        w_next_state = DIV_IDLE;
      end
      default: begin
        w_next_state = DIV_IDLE;
      end
    endcase
    if (annul) begin
      w_next_state = DIV_IDLE;
      ready        = 1'b0;
    end
    if (rst) begin
      stall = 1'b0;
      ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_a_raw    <= '0;
      r_qsign    <= 1'b0;
      r_rsign    <= 1'b0;
      r_div_zero <= 1'b0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_quot     <= w_a_abs;
      r_rem      <= '0;
      r_divisor  <= w_b_abs;
      r_a_raw    <= opdata_a;
      r_qsign    <= (opdata_a[WIDTH-1] ^ opdata_b[WIDTH-1]) & signed_div;
      r_rsign    <= opdata_a[WIDTH-1] & signed_div;
      r_div_zero <= w_b_zero;
`ifdef DIV_ZERO_FAST_EN
      if (w_b_zero) begin
        r_result <= {opdata_a, {WIDTH{1'b1}}};
      end
`endif
    end else if ((r_state == DIV_CALC) && !annul) begin
      r_cnt  <= r_cnt + CNT_W'(1);
      r_quot <= w_quot_next;
      r_rem  <= w_step_rem;
      // Result is loaded on entry to DONE so it is valid during the ready pulse.
      if (w_last) begin
        r_result <= w_final;
      end
    end
  end

  assign result = r_result;

endmodule : div_sequencer

`default_nettype wire
